// File: rtl/alu_shift_acc.sv
// -----------------------------------------------------------------------------
// alu_shift_acc
//
// Post-ALU writeback stage. Accepts an ALU result and carry-out over a
// valid/ready handshake, optionally shifts or rotates it one bit per clock,
// then commits the value to the accumulator and updates the Z/N/C flags.
//
// Optional feature macro:
//   ROTATE_EN  - when defined, shop 100 (ROL) and 101 (ROR) rotate.
//                When undefined, the rotate datapath is left out and
//                100/101 behave as pass.
//
// Parameters:
//   N    - data width (power of two, >= 2)
//   SHW  - shift-amount width, $clog2(N) (derived)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   in_valid  in   operation offered
//   in_ready  out  block can accept (IDLE and not in reset)
//   result    in   [N-1:0]   ALU result
//   cin       in   ALU carry-out
//   shop      in   [2:0]     shift op (000 pass, 001 SLL, 010 SRL, 011 SRA,
//                            100 ROL, 101 ROR, 11x pass)
//   shamt     in   [SHW-1:0] shift count
//   acc       out  [N-1:0]   accumulator
//   flag_z    out  zero flag
//   flag_n    out  negative flag (acc MSB)
//   flag_c    out  carry flag
//   done      out  one-cycle pulse after a commit
//   busy      out  operation in flight
// -----------------------------------------------------------------------------
module alu_shift_acc #(
    parameter  int N   = 8,
    localparam int SHW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   result,
    input  logic           cin,
    input  logic [2:0]     shop,
    input  logic [SHW-1:0] shamt,
    output logic [N-1:0]   acc,
    output logic           flag_z,
    output logic           flag_n,
    output logic           flag_c,
    output logic           done,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WB    = 2'd2
    } state_t;

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1'b1);

    state_t         state_r;
    state_t         state_nxt_s;
    logic [N-1:0]   work_r;
    logic           c_r;
    logic [SHW-1:0] cnt_r;
    logic [2:0]     op_r;
    logic           xfer_s;
    logic [SHW-1:0] k_s;
    logic [N:0]     step_s;

    // True for ops that use shamt; rotates only count when the rotate
    // datapath is built, otherwise they fall through to pass.
    function automatic logic is_shift_op(input logic [2:0] op);
        logic r;
        case (op)
            3'b001, 3'b010, 3'b011: r = 1'b1;
`ifdef ROTATE_EN
            3'b100, 3'b101:         r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // One shift/rotate step; returns {carry_out, new_work}. Unknown ops
    // leave work and carry untouched (never reached from SHIFT).
    function automatic logic [N:0] shift_step(input logic [N-1:0] w,
                                              input logic [2:0]   op,
                                              input logic         c);
        logic [N:0] r;
        case (op)
            3'b001:  r = {w[N-1], w[N-2:0], 1'b0};
            3'b010:  r = {w[0], 1'b0, w[N-1:1]};
            3'b011:  r = {w[0], w[N-1], w[N-1:1]};
`ifdef ROTATE_EN
            3'b100:  r = {w[N-1], w[N-2:0], w[N-1]};
            3'b101:  r = {w[0], w[0], w[N-1:1]};
`endif
            default: r = {c, w};
        endcase
        return r;
    endfunction

    assign in_ready = (state_r == IDLE) & ~rst;
    assign busy     = (state_r != IDLE);
    assign xfer_s   = in_valid & in_ready;
    assign k_s      = is_shift_op(shop) ? shamt : CNT_ZERO;
    assign step_s   = shift_step(work_r, op_r, c_r);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    if (k_s != CNT_ZERO) begin
                        state_nxt_s = SHIFT;
                    end else begin
                        state_nxt_s = WB;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = WB;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            WB:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Working datapath: capture on accept, step while shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_r <= {N{1'b0}};
            c_r    <= 1'b0;
            cnt_r  <= CNT_ZERO;
            op_r   <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        work_r <= result;
                        c_r    <= cin;
                        cnt_r  <= k_s;
                        op_r   <= shop;
                    end
                end
                SHIFT: begin
                    work_r <= step_s[N-1:0];
                    c_r    <= step_s[N];
                    cnt_r  <= cnt_r - CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // Architectural outputs: accumulator, flags and done pulse commit in WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= {N{1'b0}};
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (state_r == WB) begin
                acc    <= work_r;
                flag_z <= (work_r == {N{1'b0}});
                flag_n <= work_r[N-1];
                flag_c <= c_r;
                done   <= 1'b1;
            end else begin
                done   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_shift_acc.sv
// -----------------------------------------------------------------------------
// tb_alu_shift_acc
//
// Self-checking bench for alu_shift_acc (N = 8). A table of single-op vectors
// with hand-computed results and latencies, followed by hand-written
// sequences for back-pressure and reset during a shift. Expectations for
// shop 100/101 follow whether ROTATE_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_shift_acc;

    localparam int N   = 8;
    localparam int SHW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   result;
    logic           cin;
    logic [2:0]     shop;
    logic [SHW-1:0] shamt;
    logic [N-1:0]   acc;
    logic           flag_z;
    logic           flag_n;
    logic           flag_c;
    logic           done;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] result;
        logic       cin;
        logic [2:0] shop;
        logic [2:0] shamt;
        logic [7:0] acc;
        logic       z;
        logic       n;
        logic       c;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    alu_shift_acc #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .result   (result),
        .cin      (cin),
        .shop     (shop),
        .shamt    (shamt),
        .acc      (acc),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_c   (flag_c),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait up to a cycle budget for done; returns cycles after the accept edge
    // (0 when the budget expires).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = cyc;
                break;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        result   = v.result;
        cin      = v.cin;
        shop     = v.shop;
        shamt    = v.shamt;
        in_valid = 1'b1;
    endtask

    task automatic check_commit(input string tag, input vec_t v, input int lat);
        check({tag, " latency"}, lat, v.lat);
        check({tag, " acc"}, {24'd0, acc}, {24'd0, v.acc});
        check({tag, " flag_z"}, {31'd0, flag_z}, {31'd0, v.z});
        check({tag, " flag_n"}, {31'd0, flag_n}, {31'd0, v.n});
        check({tag, " flag_c"}, {31'd0, flag_c}, {31'd0, v.c});
    endtask

    task automatic do_op(input string tag, input vec_t v);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        drive(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        check_commit(tag, v, lat);
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1;
        vec_t v2;
        int   lat;
        int   stall;
        int   seen_done;

        //           result  cin   shop    shamt  acc    z     n     c     lat
        vecs[0]  = '{8'h00, 1'b1, 3'b000, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1};
        vecs[1]  = '{8'h96, 1'b0, 3'b001, 3'd3, 8'hB0, 1'b0, 1'b1, 1'b0, 4};
        vecs[2]  = '{8'h83, 1'b0, 3'b011, 3'd2, 8'hE0, 1'b0, 1'b1, 1'b1, 3};
        vecs[3]  = '{8'h81, 1'b0, 3'b010, 3'd1, 8'h40, 1'b0, 1'b0, 1'b1, 2};
        vecs[4]  = '{8'h7F, 1'b1, 3'b001, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b1, 1};
        vecs[5]  = '{8'h80, 1'b0, 3'b110, 3'd5, 8'h80, 1'b0, 1'b1, 1'b0, 1};
        vecs[6]  = '{8'h80, 1'b1, 3'b010, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0, 8};
        vecs[7]  = '{8'h40, 1'b0, 3'b011, 3'd7, 8'h00, 1'b1, 1'b0, 1'b1, 8};
`ifdef ROTATE_EN
        vecs[8]  = '{8'h01, 1'b0, 3'b101, 3'd1, 8'h80, 1'b0, 1'b1, 1'b1, 2};
        vecs[9]  = '{8'h81, 1'b0, 3'b100, 3'd4, 8'h18, 1'b0, 1'b0, 1'b0, 5};
`else
        vecs[8]  = '{8'h01, 1'b0, 3'b101, 3'd1, 8'h01, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{8'h81, 1'b0, 3'b100, 3'd4, 8'h81, 1'b0, 1'b1, 1'b0, 1};
`endif
        vecs[10] = '{8'hFF, 1'b0, 3'b001, 3'd1, 8'hFE, 1'b0, 1'b1, 1'b1, 2};

        rst      = 1'b1;
        in_valid = 1'b0;
        result   = 8'h00;
        cin      = 1'b0;
        shop     = 3'b000;
        shamt    = 3'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset acc", {24'd0, acc}, 32'd0);
        check("reset flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven single ops
        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-pressure: SLL by 7 with a pass held on in_valid behind it
        v1 = '{8'h01, 1'b1, 3'b001, 3'd7, 8'h80, 1'b0, 1'b1, 1'b0, 8};
        v2 = '{8'h3C, 1'b1, 3'b000, 3'd0, 8'h3C, 1'b0, 1'b0, 1'b1, 1};
        @(negedge clk);
        drive(v1);
        @(posedge clk);
        #1;
        drive(v2);
        stall = 0;
        while (!in_ready && stall < 40) begin
            stall++;
            check("bp busy while stalled", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        check("bp in_ready low cycles", stall, 32'd8);
        check("bp done in accept cycle", {31'd0, done}, 32'd1);
        check_commit("bp op1", v1, 8);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        check_commit("bp op2", v2, lat);

        // Reset during an SRL by 5 on 0xFF after two shift edges
        v1 = '{8'hFF, 1'b1, 3'b010, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 6};
        @(negedge clk);
        drive(v1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid-shift busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort acc", {24'd0, acc}, 32'd0);
        check("abort flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1;
        end
        check("abort no done", seen_done, 32'd0);
        check("abort acc held", {24'd0, acc}, 32'd0);
        v2 = '{8'h5A, 1'b0, 3'b000, 3'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 1};
        do_op("after reset pass", v2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
